// File: rtl/bj_step_seq_if.sv
// Request/response handshake bundle for the BlackJack step engine.
// The engine uses the slave modport and the agent loop uses the master modport.
interface bj_step_seq_if #(
  parameter int STA_WL = 160,
  parameter int OBS_WL = 32,
  parameter int RWD_WL = 2
);
  logic              i_valid;
  logic              o_ready;
  logic [STA_WL-1:0] i_sta;
  logic              i_act;
  logic [STA_WL-1:0] o_sta;
  logic [OBS_WL-1:0] o_obs;
  logic [RWD_WL-1:0] o_rwd;
  logic              o_done;
  logic              o_valid;
  logic              i_ready;

  modport slave (
    input  i_valid, i_sta, i_act, i_ready,
    output o_ready, o_sta, o_obs, o_rwd, o_done, o_valid
  );

  modport master (
    output i_valid, i_sta, i_act, i_ready,
    input  o_ready, o_sta, o_obs, o_rwd, o_done, o_valid
  );
endinterface

// File: rtl/bj_step_seq.sv
// BlackJack environment step engine: takes a state and action, draws cards from
// an LFSR with rejection sampling, plays out the dealer and returns the next step.
module bj_step_seq #(
  parameter int          CARD_WL             = 4,
  parameter int          PLAYER_MAX_CARD_NUM = 21,
  parameter int          DEALER_MAX_CARD_NUM = 17,
  parameter int          MAX_SUM             = 31,
  parameter int          STA_WL              = 160,
  parameter int          OBS_WL              = 32,
  parameter int          RWD_WL              = 2,
  parameter logic [15:0] LFSR_SEED           = 16'hACE1,
  parameter bit          HIT_SOFT17          = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_ena,
  input  logic         i_seed_vld,
  input  logic [15:0]  i_seed,
  bj_step_seq_if.slave bus
);
  localparam int SUM_WL    = $clog2(MAX_SUM + 1);
  localparam int P_WL      = PLAYER_MAX_CARD_NUM * CARD_WL;
  localparam int D_WL      = DEALER_MAX_CARD_NUM * CARD_WL;
  localparam int MAX_SLOTS = (PLAYER_MAX_CARD_NUM > DEALER_MAX_CARD_NUM) ?
                             PLAYER_MAX_CARD_NUM : DEALER_MAX_CARD_NUM;
  localparam int HAND_WL   = MAX_SLOTS * CARD_WL;
  localparam int CNT_WL    = $clog2(MAX_SLOTS + 1);

  localparam logic [SUM_WL-1:0] SCORE_21 = SUM_WL'(21);
  localparam logic [SUM_WL-1:0] SCORE_17 = SUM_WL'(17);
  localparam logic [RWD_WL-1:0] RWD_POS  = RWD_WL'(1);
  localparam logic [RWD_WL-1:0] RWD_NEG  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW_P, S_DEALER, S_DRAW_D, S_SCORE, S_OUT
  } state_t;

  typedef struct packed {
    logic [CNT_WL-1:0] count;
    logic [SUM_WL-1:0] score;
    logic              usable;
  } hand_t;

  // Cards after the first empty slot are ignored; the sum saturates at MAX_SUM.
  function automatic hand_t eval_hand(input logic [HAND_WL-1:0] cards, input int nslots);
    hand_t h;
    int    raw;
    bit    stop;
    bit    ace;
    h    = '0;
    raw  = 0;
    stop = 1'b0;
    ace  = 1'b0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      if (i < nslots && !stop) begin
        if (cards[i*CARD_WL +: CARD_WL] == '0) begin
          stop = 1'b1;
        end else begin
          h.count = CNT_WL'(i + 1);
          raw     = raw + int'(cards[i*CARD_WL +: CARD_WL]);
          if (raw > MAX_SUM) raw = MAX_SUM;
          if (cards[i*CARD_WL +: CARD_WL] == CARD_WL'(1)) ace = 1'b1;
        end
      end
    end
    h.usable = ace && (raw + 10 <= 21);
    h.score  = SUM_WL'(h.usable ? raw + 10 : raw);
    return h;
  endfunction

  state_t            state_q;
  logic [P_WL-1:0]   player_q;
  logic [D_WL-1:0]   dealer_q;
  logic              act_q;
  logic [15:0]       lfsr_q;
  logic [STA_WL-1:0] sta_q;
  logic [OBS_WL-1:0] obs_q;
  logic [RWD_WL-1:0] rwd_q;
  logic              done_q;
  logic              valid_q;

  hand_t player_h;
  hand_t dealer_h;
  assign player_h = eval_hand(HAND_WL'(player_q), PLAYER_MAX_CARD_NUM);
  assign dealer_h = eval_hand(HAND_WL'(dealer_q), DEALER_MAX_CARD_NUM);

  logic player_full, dealer_full, player_bust, dealer_bust, dealer_need;
  assign player_full = (player_h.count == CNT_WL'(PLAYER_MAX_CARD_NUM));
  assign dealer_full = (dealer_h.count == CNT_WL'(DEALER_MAX_CARD_NUM));
  assign player_bust = (player_h.score > SCORE_21);
  assign dealer_bust = (dealer_h.score > SCORE_21);
  assign dealer_need = (dealer_h.score < SCORE_17) ||
                       (HIT_SOFT17 && dealer_h.score == SCORE_17 && dealer_h.usable);

  // Values 13..15 are rejected so the 13 accepted values map to a uniform rank.
  logic [3:0]         rnd;
  logic               draw_ok;
  logic [CARD_WL-1:0] draw_card;
  logic [15:0]        lfsr_next;
  assign rnd       = lfsr_q[3:0];
  assign draw_ok   = (rnd < 4'd13);
  assign draw_card = (rnd < 4'd9) ? CARD_WL'(rnd + 4'd1) : CARD_WL'(10);
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  logic [RWD_WL-1:0] rwd_d;
  logic              done_d;

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    rwd_d  = '0;
    done_d = 1'b0;
    if (!act_q) begin
      done_d = 1'b1;
      if (player_bust)                          rwd_d = RWD_NEG;
      else if (dealer_bust)                     rwd_d = RWD_POS;
      else if (player_h.score > dealer_h.score) rwd_d = RWD_POS;
      else if (player_h.score < dealer_h.score) rwd_d = RWD_NEG;
    end else if (player_bust || player_full) begin
      rwd_d  = RWD_NEG;
      done_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      // NOTE: the hand registers are reset as well, so an aborted step leaves no stale cards.
      state_q  <= S_IDLE;
      player_q <= '0;
      dealer_q <= '0;
      act_q    <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      sta_q    <= '0;
      obs_q    <= '0;
      rwd_q    <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (i_ena) begin
      case (state_q)
        S_IDLE: begin
          if (i_seed_vld) lfsr_q <= (i_seed == 16'h0) ? LFSR_SEED : i_seed;
          if (bus.i_valid) begin
            player_q <= bus.i_sta[P_WL-1:0];
            dealer_q <= bus.i_sta[P_WL +: D_WL];
            act_q    <= bus.i_act;
            state_q  <= bus.i_act ? S_DRAW_P : S_DEALER;
          end
        end
        S_DRAW_P: begin
          if (player_full) begin
            state_q <= S_SCORE;
          end else begin
            lfsr_q <= lfsr_next;
            if (draw_ok) begin
              player_q[int'(player_h.count)*CARD_WL +: CARD_WL] <= draw_card;
              state_q <= S_SCORE;
            end
          end
        end
        S_DEALER: begin
          state_q <= (dealer_need && !dealer_full) ? S_DRAW_D : S_SCORE;
        end
        S_DRAW_D: begin
          lfsr_q <= lfsr_next;
          if (draw_ok) begin
            dealer_q[int'(dealer_h.count)*CARD_WL +: CARD_WL] <= draw_card;
            state_q <= S_DEALER;
          end
        end
        S_SCORE: begin
          sta_q   <= STA_WL'({dealer_q, player_q});
          obs_q   <= OBS_WL'({player_h.score, dealer_q[CARD_WL-1:0], player_h.usable});
          rwd_q   <= rwd_d;
          done_q  <= done_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          // o_valid rises one edge after the results are registered.
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (bus.i_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready = i_ena && (state_q == S_IDLE);
  assign bus.o_sta   = sta_q;
  assign bus.o_obs   = obs_q;
  assign bus.o_rwd   = rwd_q;
  assign bus.o_done  = done_q;
  assign bus.o_valid = valid_q;

  generate
    if (STA_WL > P_WL + D_WL) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^bus.i_sta[STA_WL-1:P_WL+D_WL];
    end
  endgenerate
endmodule

// File: tb/tb_bj_step_seq.sv
// Scoreboard bench for bj_step_seq: directed steps with hand-computed results,
// checked by an independent monitor whenever a response appears.
module tb_bj_step_seq;
  localparam int CW     = 4;
  localparam int PN     = 21;
  localparam int DN     = 17;
  localparam int STA_WL = 160;
  localparam int OBS_WL = 32;
  localparam int RWD_WL = 2;
  localparam int P_W    = PN * CW;
  localparam int D_W    = DN * CW;

  localparam logic [1:0] R_POS  = 2'b01;
  localparam logic [1:0] R_ZERO = 2'b00;
  localparam logic [1:0] R_NEG  = 2'b11;

  typedef logic [P_W-1:0] phand_t;
  typedef logic [D_W-1:0] dhand_t;

  typedef struct {
    logic [STA_WL-1:0] sta;
    logic [OBS_WL-1:0] obs;
    logic [RWD_WL-1:0] rwd;
    logic              done;
    int                lat;
    logic [15:0]       lfsr;
    int                acc;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  always #5 clk = ~clk;

  logic              sel, valid, act, ready, seed_vld;
  logic [STA_WL-1:0] sta;
  logic [15:0]       seed;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  bj_step_seq_if #(.STA_WL(STA_WL), .OBS_WL(OBS_WL), .RWD_WL(RWD_WL)) if_a ();
  bj_step_seq_if #(.STA_WL(STA_WL), .OBS_WL(OBS_WL), .RWD_WL(RWD_WL)) if_b ();

  assign if_a.i_valid = valid & ~sel;
  assign if_b.i_valid = valid & sel;
  assign if_a.i_sta   = sta;
  assign if_b.i_sta   = sta;
  assign if_a.i_act   = act;
  assign if_b.i_act   = act;
  assign if_a.i_ready = ready;
  assign if_b.i_ready = ready;

  bj_step_seq #(.HIT_SOFT17(1'b0)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_ena(ena),
    .i_seed_vld(seed_vld & ~sel), .i_seed(seed), .bus(if_a)
  );

  bj_step_seq #(.HIT_SOFT17(1'b1)) dut_s17 (
    .i_clk(clk), .i_rstn(rst_n), .i_ena(ena),
    .i_seed_vld(seed_vld & sel), .i_seed(seed), .bus(if_b)
  );

  logic              m_ready, m_valid, m_done;
  logic [STA_WL-1:0] m_sta;
  logic [OBS_WL-1:0] m_obs;
  logic [RWD_WL-1:0] m_rwd;
  logic [15:0]       m_lfsr;
  assign m_ready = sel ? if_b.o_ready : if_a.o_ready;
  assign m_valid = sel ? if_b.o_valid : if_a.o_valid;
  assign m_done  = sel ? if_b.o_done  : if_a.o_done;
  assign m_sta   = sel ? if_b.o_sta   : if_a.o_sta;
  assign m_obs   = sel ? if_b.o_obs   : if_a.o_obs;
  assign m_rwd   = sel ? if_b.o_rwd   : if_a.o_rwd;
  assign m_lfsr  = sel ? dut_s17.lfsr_q : dut.lfsr_q;

  task automatic check(input string name, input logic [STA_WL-1:0] got, input logic [STA_WL-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic phand_t hand(input int c0, input int c1, input int c2, input int c3);
    phand_t h;
    h = '0;
    h[0*CW +: CW] = CW'(c0);
    h[1*CW +: CW] = CW'(c1);
    h[2*CW +: CW] = CW'(c2);
    h[3*CW +: CW] = CW'(c3);
    return h;
  endfunction

  function automatic logic [OBS_WL-1:0] mk_obs(input int score, input int card0, input int usable);
    return OBS_WL'((score << 5) | (card0 << 1) | usable);
  endfunction

  // Monitor: each rising o_valid pops one expected response.
  logic prev_valid = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= m_valid;
      if (m_valid && !prev_valid) begin
        if (q.size() == 0) begin
          check("unexpected_output", m_valid, 1'b0);
        end else begin
          mon_e = q.pop_front();
          check("sta",     m_sta, mon_e.sta);
          check("obs",     m_obs, mon_e.obs);
          check("rwd",     m_rwd, mon_e.rwd);
          check("done",    m_done, mon_e.done);
          check("latency", STA_WL'(cyc - mon_e.acc), STA_WL'(mon_e.lat));
          check("lfsr",    m_lfsr, mon_e.lfsr);
        end
      end
    end
  end

  task automatic run(input bit s, input phand_t p, input dhand_t d, input bit a,
                     input bit ld, input logic [15:0] sd,
                     input phand_t p_out, input dhand_t d_out,
                     input int score, input int card0, input int usable,
                     input logic [1:0] rwd, input bit done, input int lat,
                     input logic [15:0] lfsr_out, input int ena_gap, input int bp);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    sel = s; sta = STA_WL'({d, p}); act = a; seed_vld = ld; seed = sd;
    valid = 1'b1; ready = (bp == 0);
    n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", m_ready, 1'b1);
    e.sta  = STA_WL'({d_out, p_out});
    e.obs  = mk_obs(score, card0, usable);
    e.rwd  = rwd;
    e.done = done;
    e.lat  = lat;
    e.lfsr = lfsr_out;
    e.acc  = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    valid = 1'b0; seed_vld = 1'b0;
    check("busy_not_ready", m_ready, 1'b0);
    n = 1;
    seen = m_valid;
    while (!seen && n < 200) begin
      if (ena_gap > 0 && n == ena_gap) ena = 1'b0;
      if (ena_gap > 0 && (n == ena_gap + 1 || n == ena_gap + 2)) check("lfsr_frozen", m_lfsr, sd);
      if (ena_gap > 0 && n == ena_gap + 2) ena = 1'b1;
      @(negedge clk);
      n++;
      seen = m_valid;
    end
    check("valid_seen", seen, 1'b1);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("hold_valid", m_valid, 1'b1);
      check("hold_sta",   m_sta, e.sta);
      check("hold_obs",   m_obs, e.obs);
      check("hold_rwd",   {m_done, m_rwd}, {e.done, e.rwd});
    end
    ready = 1'b1;
    @(negedge clk);
    check("valid_drop", m_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; valid = 1'b0; act = 1'b0; ready = 1'b1;
    seed_vld = 1'b0; seed = 16'h0; sta = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", m_valid, 1'b0);
    check("rst_sta",   m_sta, '0);
    check("rst_obs",   m_obs, '0);
    check("rst_rwd",   {m_done, m_rwd}, 3'b000);
    check("rst_lfsr",  m_lfsr, 16'hACE1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", m_ready, 1'b1);

    // STICK, no dealer draw, LFSR untouched from reset value
    run(0, hand(10,9,0,0), D_W'(hand(10,7,0,0)), 0, 0, 16'h0000,
        hand(10,9,0,0), D_W'(hand(10,7,0,0)), 19, 10, 0, R_POS, 1, 3, 16'hACE1, 0, 0);
    // HIT into certain bust: r=1 gives card 2
    run(0, hand(10,10,2,0), D_W'(hand(10,7,0,0)), 1, 1, 16'h0001,
        hand(10,10,2,2), D_W'(hand(10,7,0,0)), 24, 10, 0, R_NEG, 1, 3, 16'h0002, 0, 0);
    // Rejection sampling: r=15, r=14 rejected, r=12 gives 10
    run(0, hand(2,3,0,0), D_W'(hand(10,7,0,0)), 1, 1, 16'h000F,
        hand(2,3,10,0), D_W'(hand(10,7,0,0)), 15, 10, 0, R_ZERO, 0, 5, 16'h0078, 0, 0);
    // Usable ace: soft 17 loses to 18
    run(0, hand(1,6,0,0), D_W'(hand(10,8,0,0)), 0, 1, 16'h1234,
        hand(1,6,0,0), D_W'(hand(10,8,0,0)), 17, 10, 1, R_NEG, 1, 3, 16'h1234, 0, 0);
    // Dealer soft 17 stands
    run(0, hand(10,9,0,0), D_W'(hand(1,6,0,0)), 0, 1, 16'h0001,
        hand(10,9,0,0), D_W'(hand(1,6,0,0)), 19, 1, 0, R_POS, 1, 3, 16'h0001, 0, 0);
    // Dealer hits soft 17: draws 2, soft 19 ties the player
    run(1, hand(10,9,0,0), D_W'(hand(1,6,0,0)), 0, 1, 16'h0001,
        hand(10,9,0,0), D_W'(hand(1,6,2,0)), 19, 1, 0, R_ZERO, 1, 5, 16'h0002, 0, 0);
    // Dealer busts after drawing 10
    run(0, hand(10,8,0,0), D_W'(hand(10,5,0,0)), 0, 1, 16'h0009,
        hand(10,8,0,0), D_W'(hand(10,5,10,0)), 18, 10, 0, R_POS, 1, 5, 16'h0012, 0, 0);
    // Player already bust on STICK
    run(0, hand(10,10,5,0), D_W'(hand(10,7,0,0)), 0, 1, 16'h0003,
        hand(10,10,5,0), D_W'(hand(10,7,0,0)), 25, 10, 0, R_NEG, 1, 3, 16'h0003, 0, 0);
    // Enable dropped mid-DRAW_D plus 5 cycles of backpressure
    run(0, hand(10,8,0,0), D_W'(hand(10,2,0,0)), 0, 1, 16'h0005,
        hand(10,8,0,0), D_W'(hand(10,2,6,0)), 18, 10, 0, R_ZERO, 1, 7, 16'h000A, 2, 5);
    // Zero seed is replaced by the default seed
    run(0, hand(10,9,0,0), D_W'(hand(10,7,0,0)), 0, 1, 16'h0000,
        hand(10,9,0,0), D_W'(hand(10,7,0,0)), 19, 10, 0, R_POS, 1, 3, 16'hACE1, 0, 0);
    // HIT from the default seed: r=1 gives card 2, LFSR steps once
    run(0, hand(5,0,0,0), D_W'(hand(10,0,0,0)), 1, 0, 16'h0000,
        hand(5,2,0,0), D_W'(hand(10,0,0,0)), 7, 10, 0, R_ZERO, 0, 3, 16'h59C3, 0, 0);

    // Mid-step reset aborts the step with no response
    @(negedge clk);
    sel = 1'b0; sta = STA_WL'({D_W'(hand(10,2,0,0)), hand(10,2,0,0)}); act = 1'b0;
    seed_vld = 1'b1; seed = 16'h000F; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; seed_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_lfsr",  m_lfsr, 16'hACE1);
    check("abort_sta",   m_sta, '0);
    check("abort_obs",   m_obs, '0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_valid", m_valid, 1'b0);
    check("abort_ready", m_ready, 1'b1);

    check("queue_drained", STA_WL'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
